// File: rtl/niosii_cpu_mul_combine.sv
// Combines the M-stage 16x16 partial products into the W-stage product word.
// Define NIOSII_MUL_HIGH_EN to build the iterative upper-word (mulxuu) engine.
module niosii_cpu_mul_combine #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        M_en,
  input  logic        M_mul_valid,
  input  logic        M_mul_high,
  input  logic [31:0] M_mul_cell_p1,
  input  logic [31:0] M_mul_cell_p2,
  input  logic [31:0] M_mul_cell_p3,
  input  logic [15:0] M_src1_hi,
  input  logic [15:0] M_src2_hi,
  output logic [31:0] W_mul_result,
  output logic        W_mul_valid,
  output logic        M_mul_stall
);

  logic [15:0] mid_s;
  logic [31:0] lo_s;
  logic [31:0] w_result_q, w_result_d;
  logic        w_valid_q, w_valid_d;

  assign mid_s = M_mul_cell_p2[15:0] + M_mul_cell_p3[15:0];
  assign lo_s  = M_mul_cell_p1 + {mid_s, 16'h0000};

  // W-stage result register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_result_q <= 32'h0000_0000;
      w_valid_q  <= 1'b0;
    end else begin
      w_result_q <= w_result_d;
      w_valid_q  <= w_valid_d;
    end
  end

  assign W_mul_result = w_result_q;
  assign W_mul_valid  = w_valid_q;

`ifdef NIOSII_MUL_HIGH_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MULT = 2'd1,
    S_ADD  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int            NUM_STEPS = 16 / BITS_PER_CYCLE;
  localparam logic [3:0]    CNT_LAST  = 4'(NUM_STEPS - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] p1_q, p2_q, p3_q;
  logic [15:0] s1_q, s2_q;
  logic        cap_s;
  logic        stall_s;
  logic [3:0]  base_s;
  logic [BITS_PER_CYCLE-1:0] digit_s;
  logic [31:0] add_s;
  logic [63:0] full_s;

  // FSM, accumulator and captured operands
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      acc_q   <= 32'h0000_0000;
      hi_q    <= 32'h0000_0000;
      p1_q    <= 32'h0000_0000;
      p2_q    <= 32'h0000_0000;
      p3_q    <= 32'h0000_0000;
      s1_q    <= 16'h0000;
      s2_q    <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      if (cap_s) begin
        p1_q <= M_mul_cell_p1;
        p2_q <= M_mul_cell_p2;
        p3_q <= M_mul_cell_p3;
        s1_q <= M_src1_hi;
        s2_q <= M_src2_hi;
      end else begin
        p1_q <= p1_q;
        p2_q <= p2_q;
        p3_q <= p3_q;
        s1_q <= s1_q;
        s2_q <= s2_q;
      end
    end
  end

  // One radix-2^BITS_PER_CYCLE digit of src1_hi*src2_hi, weighted by position
  always_comb begin
    base_s  = cnt_q * 4'(BITS_PER_CYCLE);
    digit_s = s2_q[base_s +: BITS_PER_CYCLE];
    add_s   = 32'h0000_0000;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      if (digit_s[j]) begin
        add_s = add_s + ({16'h0000, s1_q} << (base_s + 4'(j)));
      end else begin
        add_s = add_s;
      end
    end
  end

  assign full_s = {32'h0000_0000, p1_q} + {16'h0000, p2_q, 16'h0000} +
                  {16'h0000, p3_q, 16'h0000} + {acc_q, 32'h0000_0000};

  // Next state, W write selection and stall request
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    hi_d       = hi_q;
    cap_s      = 1'b0;
    stall_s    = 1'b0;
    w_result_d = w_result_q;
    w_valid_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (M_mul_valid && M_mul_high) begin
          cap_s   = 1'b1;
          acc_d   = 32'h0000_0000;
          cnt_d   = 4'd0;
          stall_s = 1'b1;
          state_d = S_MULT;
        end else if (M_en && M_mul_valid) begin
          w_result_d = lo_s;
          w_valid_d  = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MULT: begin
        stall_s = 1'b1;
        acc_d   = acc_q + add_s;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = 4'd0;
          state_d = S_ADD;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_ADD: begin
        stall_s = 1'b1;
        hi_d    = full_s[63:32];
        state_d = S_DONE;
      end
      S_DONE: begin
        // The request still visible here is the instruction just finished.
        if (M_en) begin
          w_result_d = hi_q;
          w_valid_d  = 1'b1;
          state_d    = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
        acc_d   = 32'h0000_0000;
      end
    endcase
  end

  assign M_mul_stall = stall_s & ~reset;
`else
  logic unused_s;
  assign unused_s = ^{M_mul_high, M_src1_hi, M_src2_hi,
                      M_mul_cell_p2[31:16], M_mul_cell_p3[31:16]};

  // Low-word only: every product is written one cycle after M advances
  always_comb begin
    w_result_d = w_result_q;
    w_valid_d  = 1'b0;
    if (M_en && M_mul_valid) begin
      w_result_d = lo_s;
      w_valid_d  = 1'b1;
    end else begin
      w_valid_d = 1'b0;
    end
  end

  assign M_mul_stall = 1'b0;
`endif

endmodule

// File: tb/tb_niosii_cpu_mul_combine.sv
// Directed bench for niosii_cpu_mul_combine: vector table plus upper-word,
// DONE-hold and mid-multiply reset sequences (upper-word paths need NIOSII_MUL_HIGH_EN).
module tb_niosii_cpu_mul_combine;

  logic        clk = 1'b0;
  logic        reset;
  logic        M_en, M_mul_valid, M_mul_high;
  logic [31:0] p1, p2, p3;
  logic [15:0] s1h, s2h;
  logic [31:0] W_mul_result;
  logic        W_mul_valid, M_mul_stall;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
  } vec_t;

  vec_t vt[7];

  niosii_cpu_mul_combine dut (
    .clk           (clk),
    .reset         (reset),
    .M_en          (M_en),
    .M_mul_valid   (M_mul_valid),
    .M_mul_high    (M_mul_high),
    .M_mul_cell_p1 (p1),
    .M_mul_cell_p2 (p2),
    .M_mul_cell_p3 (p3),
    .M_src1_hi     (s1h),
    .M_src2_hi     (s2h),
    .W_mul_result  (W_mul_result),
    .W_mul_valid   (W_mul_valid),
    .M_mul_stall   (M_mul_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_ops(input logic [31:0] a, input logic [31:0] b);
    p1  = {16'h0000, a[15:0]}  * {16'h0000, b[15:0]};
    p2  = {16'h0000, a[15:0]}  * {16'h0000, b[31:16]};
    p3  = {16'h0000, a[31:16]} * {16'h0000, b[15:0]};
    s1h = a[31:16];
    s2h = b[31:16];
  endtask

  task automatic do_low(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
    set_ops(a, b);
    M_mul_high  = 1'b0;
    M_mul_valid = 1'b1;
    M_en        = 1'b1;
    #1;
    chk({name, "_nostall"}, {31'd0, M_mul_stall}, 32'd0);
    @(posedge clk); #1;
    chk({name, "_valid"}, {31'd0, W_mul_valid}, 32'd1);
    chk({name, "_lo"}, W_mul_result, exp);
    M_mul_valid = 1'b0;
    M_en        = 1'b0;
    @(posedge clk); #1;
    chk({name, "_pulse"}, {31'd0, W_mul_valid}, 32'd0);
    chk({name, "_hold"}, W_mul_result, exp);
  endtask

  task automatic do_high(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] lo, input logic [31:0] hi, input int hold);
    logic [31:0] prev;
    int n;
    set_ops(a, b);
    M_mul_high  = 1'b1;
    M_mul_valid = 1'b1;
`ifdef NIOSII_MUL_HIGH_EN
    M_en = 1'b0;
    #1;
    chk({name, "_stall_req"}, {31'd0, M_mul_stall}, 32'd1);
    @(posedge clk); #1;
    n = 0;
    while (M_mul_stall && n < 40) begin
      chk({name, "_nowrite"}, {31'd0, W_mul_valid}, 32'd0);
      n++;
      @(posedge clk); #1;
    end
    chk({name, "_stall_len"}, n, 32'd17);
    prev = W_mul_result;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({name, "_done_valid"}, {31'd0, W_mul_valid}, 32'd0);
      chk({name, "_done_stall"}, {31'd0, M_mul_stall}, 32'd0);
      chk({name, "_done_hold"}, W_mul_result, prev);
    end
    M_en = 1'b1;
    @(posedge clk); #1;
    chk({name, "_valid"}, {31'd0, W_mul_valid}, 32'd1);
    chk({name, "_hi"}, W_mul_result, hi);
    M_mul_valid = 1'b0;
    M_mul_high  = 1'b0;
    M_en        = 1'b0;
    @(posedge clk); #1;
    chk({name, "_single"}, {31'd0, W_mul_valid}, 32'd0);
    chk({name, "_hi_hold"}, W_mul_result, hi);
`else
    prev = hi;
    n    = hold;
    M_en = 1'b1;
    #1;
    chk({name, "_nostall"}, {31'd0, M_mul_stall}, 32'd0);
    @(posedge clk); #1;
    chk({name, "_valid"}, {31'd0, W_mul_valid}, 32'd1);
    chk({name, "_lo"}, W_mul_result, lo);
    M_mul_valid = 1'b0;
    M_mul_high  = 1'b0;
    M_en        = 1'b0;
    @(posedge clk); #1;
    chk({name, "_pulse"}, {31'd0, W_mul_valid}, 32'd0);
`endif
  endtask

  initial begin
    vt[0] = '{a: 32'h0001_0002, b: 32'h0003_0004, lo: 32'h000A_0008, hi: 32'h0000_0003};
    vt[1] = '{a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, lo: 32'h0000_0001, hi: 32'hFFFF_FFFE};
    vt[2] = '{a: 32'h0000_0003, b: 32'h0000_0005, lo: 32'h0000_000F, hi: 32'h0000_0000};
    vt[3] = '{a: 32'h1234_5678, b: 32'h0000_0010, lo: 32'h2345_6780, hi: 32'h0000_0001};
    vt[4] = '{a: 32'h8000_0000, b: 32'h0000_0002, lo: 32'h0000_0000, hi: 32'h0000_0001};
    vt[5] = '{a: 32'h0001_0000, b: 32'h0001_0000, lo: 32'h0000_0000, hi: 32'h0000_0001};
    vt[6] = '{a: 32'hFFFF_0000, b: 32'h0002_0000, lo: 32'h0000_0000, hi: 32'h0001_FFFE};

    reset = 1'b1;
    M_en = 1'b0; M_mul_valid = 1'b0; M_mul_high = 1'b0;
    p1 = 32'd0; p2 = 32'd0; p3 = 32'd0; s1h = 16'd0; s2h = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_result", W_mul_result, 32'd0);
    chk("rst_valid", {31'd0, W_mul_valid}, 32'd0);
    chk("rst_stall", {31'd0, M_mul_stall}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_nowrite", {31'd0, W_mul_valid}, 32'd0);

    for (int i = 0; i < 7; i++) begin
      do_low($sformatf("low%0d", i), vt[i].a, vt[i].b, vt[i].lo);
    end
    for (int i = 0; i < 7; i++) begin
      do_high($sformatf("high%0d", i), vt[i].a, vt[i].b, vt[i].lo, vt[i].hi, 0);
    end
    do_high("done_hold", vt[1].a, vt[1].b, vt[1].lo, vt[1].hi, 5);

    // Reset pulsed in the middle of an upper-word multiply
    do_low("pre_rst", vt[1].a, vt[1].b, vt[1].lo);
    set_ops(vt[1].a, vt[1].b);
    M_mul_high  = 1'b1;
    M_mul_valid = 1'b1;
    M_en        = 1'b0;
`ifdef NIOSII_MUL_HIGH_EN
    @(posedge clk);
    repeat (7) @(posedge clk);
    #1;
    chk("mult7_stall", {31'd0, M_mul_stall}, 32'd1);
`endif
    reset = 1'b1;
    #1;
    chk("midrst_stall", {31'd0, M_mul_stall}, 32'd0);
    chk("midrst_result", W_mul_result, 32'd0);
    chk("midrst_valid", {31'd0, W_mul_valid}, 32'd0);
    M_mul_valid = 1'b0;
    M_mul_high  = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("after_rst_valid", {31'd0, W_mul_valid}, 32'd0);
    chk("after_rst_result", W_mul_result, 32'd0);
    chk("after_rst_stall", {31'd0, M_mul_stall}, 32'd0);
    do_low("post_rst_low", 32'h0000_0003, 32'h0000_0005, 32'h0000_000F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
